// File: rtl/lc3_pkg.sv
// Shared LC3 pipeline definitions: opcodes, control-word encodings and field
// positions, plus sign-extension and condition-code helpers.
package lc3_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LEA = 4'b1110;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_RSVD = 2'b11
   } alu_ctl_t;

   typedef enum logic [1:0] {
      PCS1_OFF11 = 2'b00,
      PCS1_OFF9  = 2'b01,
      PCS1_OFF6  = 2'b10,
      PCS1_ZERO  = 2'b11
   } pcsel1_t;

   typedef enum logic [1:0] {
      WB_ALU   = 2'b00,
      WB_RSVD1 = 2'b01,
      WB_PC    = 2'b10,
      WB_RSVD3 = 2'b11
   } wctl_t;

   // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
   localparam int EC_ALU_LSB  = 4;
   localparam int EC_PCS1_LSB = 2;
   localparam int EC_PCS2_BIT = 1;
   localparam int EC_OP2_BIT  = 0;

   // Replicates bit msb into every higher bit; lower bits pass through, so
   // sext(IR, 8) yields the sign-extended IR[8:0] directly.
   function automatic logic [15:0] sext(input logic [15:0] val, input logic [3:0] msb);
      logic [15:0] upper;
      upper = 16'hFFFF << msb;
      return val[msb] ? (val | upper) : (val & ~upper);
   endfunction

   function automatic logic [2:0] nzp_of(input logic [15:0] val);
      if (val[15])
         return 3'b100;
      else if (val == 16'h0000)
         return 3'b010;
      else
         return 3'b001;
   endfunction

endpackage

// File: rtl/exec_alu.sv
// Execute-stage ALU: second-operand select (register or imm5) and the
// add / and / not operations.
module exec_alu
   import lc3_pkg::*;
(
   input  alu_ctl_t    alu_control,
   input  logic        op2select,
   input  logic [15:0] IR,
   input  logic [15:0] VSR1,
   input  logic [15:0] VSR2,
   output logic [15:0] aluout
);

   logic [15:0] op2;

   assign op2 = op2select ? VSR2 : sext(IR, 4'd4);

   always_comb begin
      aluout = 16'h0000;
      case (alu_control)
         ALU_ADD: aluout = VSR1 + op2;
         ALU_AND: aluout = VSR1 & op2;
         ALU_NOT: aluout = ~VSR1;
         default: aluout = 16'h0000;
      endcase
   end

endmodule

// File: rtl/execute.sv
// LC3 execute stage: ALU, PC-relative address generation and condition codes,
// all captured into one rank of enable-gated registers for writeback.
module execute
   import lc3_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_execute,
   input  logic [15:0] IR,
   input  logic [15:0] npc_in,
   input  logic [5:0]  E_Control,
   input  logic [1:0]  W_Control_in,
   input  logic [15:0] VSR1,
   input  logic [15:0] VSR2,
   output logic [2:0]  sr1,
   output logic [2:0]  sr2,
   output logic [15:0] aluout,
   output logic [15:0] pcout,
   output logic [2:0]  dr,
   output logic [1:0]  W_Control_out,
   output logic [15:0] IR_Exec,
   output logic [2:0]  NZP
);

   alu_ctl_t    alu_control;
   pcsel1_t     pcselect1;
   logic        pcselect2;
   logic        op2select;

   logic [15:0] alu_next;
   logic [15:0] offset;
   logic [15:0] base;
   logic [15:0] pc_next;
   logic [2:0]  nzp_next;

   logic [15:0] aluout_reg;
   logic [15:0] pcout_reg;
   logic [2:0]  dr_reg;
   logic [1:0]  w_control_reg;
   logic [15:0] ir_exec_reg;
   logic [2:0]  nzp_reg;

   // Register addresses go straight back to the register file this cycle
   assign sr1 = IR[8:6];
   assign sr2 = IR[2:0];

   assign alu_control = alu_ctl_t'(E_Control[EC_ALU_LSB +: 2]);
   assign pcselect1   = pcsel1_t'(E_Control[EC_PCS1_LSB +: 2]);
   assign pcselect2   = E_Control[EC_PCS2_BIT];
   assign op2select   = E_Control[EC_OP2_BIT];

   exec_alu u_exec_alu (
      .alu_control (alu_control),
      .op2select   (op2select),
      .IR          (IR),
      .VSR1        (VSR1),
      .VSR2        (VSR2),
      .aluout      (alu_next)
   );

   always_comb begin
      offset = 16'h0000;
      case (pcselect1)
         PCS1_OFF11: offset = sext(IR, 4'd10);
         PCS1_OFF9:  offset = sext(IR, 4'd8);
         PCS1_OFF6:  offset = sext(IR, 4'd5);
         default:    offset = 16'h0000;
      endcase
   end

   assign base    = pcselect2 ? npc_in : VSR1;
   assign pc_next = base + offset;

   // Flags follow whichever value writeback will commit
   always_comb begin
      nzp_next = 3'b000;
      case (wctl_t'(W_Control_in))
         WB_ALU:  nzp_next = nzp_of(alu_next);
         WB_PC:   nzp_next = nzp_of(pc_next);
         default: nzp_next = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aluout_reg    <= 16'h0000;
         pcout_reg     <= 16'h0000;
         dr_reg        <= 3'b000;
         w_control_reg <= 2'b00;
         ir_exec_reg   <= 16'h0000;
         nzp_reg       <= 3'b000;
      end else if (enable_execute) begin
         aluout_reg    <= alu_next;
         pcout_reg     <= pc_next;
         dr_reg        <= IR[11:9];
         w_control_reg <= W_Control_in;
         ir_exec_reg   <= IR;
         nzp_reg       <= nzp_next;
      end
   end

   assign aluout        = aluout_reg;
   assign pcout         = pcout_reg;
   assign dr            = dr_reg;
   assign W_Control_out = w_control_reg;
   assign IR_Exec       = ir_exec_reg;
   assign NZP           = nzp_reg;

endmodule

// File: tb/tb_execute.sv
// Bench for the LC3 execute stage: an arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_execute;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_execute;
   logic [15:0] IR, npc_in, VSR1, VSR2;
   logic [5:0]  E_Control;
   logic [1:0]  W_Control_in;
   logic [2:0]  sr1, sr2, dr, NZP;
   logic [15:0] aluout, pcout, IR_Exec;
   logic [1:0]  W_Control_out;

   int checks = 0;
   int errors = 0;

   execute dut (
      .clk            (clk),
      .rst            (rst),
      .enable_execute (enable_execute),
      .IR             (IR),
      .npc_in         (npc_in),
      .E_Control      (E_Control),
      .W_Control_in   (W_Control_in),
      .VSR1           (VSR1),
      .VSR2           (VSR2),
      .sr1            (sr1),
      .sr2            (sr2),
      .aluout         (aluout),
      .pcout          (pcout),
      .dr             (dr),
      .W_Control_out  (W_Control_out),
      .IR_Exec        (IR_Exec),
      .NZP            (NZP)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Two's-complement interpretation of a bits-wide field, as an integer
   function automatic logic [15:0] sx(input int val, input int bits);
      int v;
      v = val & ((1 << bits) - 1);
      if (v >= (1 << (bits - 1)))
         v = v - (1 << bits);
      return 16'(v);
   endfunction

   function automatic logic [2:0] flags(input logic [15:0] v);
      if (v == 16'h0000)      return 3'b010;
      else if (v >= 16'h8000) return 3'b100;
      else                    return 3'b001;
   endfunction

   // Reference model state: what the registered outputs must hold
   logic [15:0] m_alu, m_pc, m_ir, m_op2, m_off, m_base;
   logic [2:0]  m_dr, m_nzp;
   logic [1:0]  m_w;
   bit          m_valid = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_alu = 0; m_pc = 0; m_dr = 0; m_w = 0; m_ir = 0; m_nzp = 0;
      end else if (enable_execute) begin
         m_op2 = E_Control[0] ? VSR2 : sx(int'(IR) % 32, 5);
         case (E_Control[5:4])
            2'd0:    m_alu = 16'((int'(VSR1) + int'(m_op2)) % 65536);
            2'd1:    m_alu = VSR1 & m_op2;
            2'd2:    m_alu = 16'hFFFF - VSR1;
            default: m_alu = 16'h0000;
         endcase
         case (E_Control[3:2])
            2'd0:    m_off = sx(int'(IR) % 2048, 11);
            2'd1:    m_off = sx(int'(IR) % 512, 9);
            2'd2:    m_off = sx(int'(IR) % 64, 6);
            default: m_off = 16'h0000;
         endcase
         m_base = E_Control[1] ? npc_in : VSR1;
         m_pc   = 16'((int'(m_base) + int'(m_off)) % 65536);
         m_dr   = 3'((int'(IR) / 512) % 8);
         m_w    = W_Control_in;
         m_ir   = IR;
         if (W_Control_in == 2'b00)      m_nzp = flags(m_alu);
         else if (W_Control_in == 2'b10) m_nzp = flags(m_pc);
         else                            m_nzp = 3'b000;
      end
      m_valid = 1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("aluout", aluout, m_alu);
         check("pcout", pcout, m_pc);
         check("dr", 16'(dr), 16'(m_dr));
         check("W_Control_out", 16'(W_Control_out), 16'(m_w));
         check("IR_Exec", IR_Exec, m_ir);
         check("NZP", 16'(NZP), 16'(m_nzp));
         check("sr1", 16'(sr1), 16'((int'(IR) / 64) % 8));
         check("sr2", 16'(sr2), 16'(int'(IR) % 8));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] ir_v, input logic [5:0] e_v, input logic [1:0] w_v,
                        input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] npc_v);
      IR = ir_v; E_Control = e_v; W_Control_in = w_v;
      VSR1 = v1; VSR2 = v2; npc_in = npc_v;
   endtask

   initial begin
      rst = 1'b1;
      enable_execute = 1'b1;
      drive(16'($urandom), 6'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      tick();
      drive(16'($urandom), 6'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      tick();
      $display("reset: aluout=%h pcout=%h NZP=%b", aluout, pcout, NZP);
      check("rst_aluout", aluout, 16'h0000);
      check("rst_pcout", pcout, 16'h0000);
      check("rst_dr", 16'(dr), 16'h0);
      check("rst_wctl", 16'(W_Control_out), 16'h0);
      check("rst_ir", IR_Exec, 16'h0000);
      check("rst_nzp", 16'(NZP), 16'h0);

      rst = 1'b0;
      enable_execute = 1'b0;
      drive(16'h1A7F, 6'b000000, 2'b00, 16'h1234, 16'h5678, 16'h3000);
      tick();
      tick();
      $display("hold after reset: aluout=%h NZP=%b", aluout, NZP);
      check("hold_aluout", aluout, 16'h0000);
      check("hold_ir", IR_Exec, 16'h0000);

      enable_execute = 1'b1;
      drive(16'h1A7F, 6'b000000, 2'b00, 16'h0000, 16'hAAAA, 16'h3000);
      #1;
      check("add_sr1", 16'(sr1), 16'h1);
      tick();
      $display("ADD imm: aluout=%h dr=%0d NZP=%b pcout=%h", aluout, dr, NZP, pcout);
      check("add_aluout", aluout, 16'hFFFF);
      check("add_dr", 16'(dr), 16'h5);
      check("add_nzp", 16'(NZP), 16'h4);
      check("add_wctl", 16'(W_Control_out), 16'h0);
      check("add_pcout", pcout, 16'h027F);
      check("model_add_alu", m_alu, 16'hFFFF);

      drive(16'h5042, 6'b010001, 2'b00, 16'hF0F0, 16'h0FF0, 16'h3000);
      tick();
      $display("AND reg: aluout=%h NZP=%b", aluout, NZP);
      check("and_aluout", aluout, 16'h00F0);
      check("and_nzp", 16'(NZP), 16'h1);

      drive(16'h5042, 6'b010001, 2'b00, 16'hF0F0, 16'h0F0F, 16'h3000);
      tick();
      $display("AND zero: aluout=%h NZP=%b", aluout, NZP);
      check("andz_aluout", aluout, 16'h0000);
      check("andz_nzp", 16'(NZP), 16'h2);

      drive(16'h927F, 6'b100000, 2'b00, 16'h00FF, 16'h1111, 16'h3000);
      tick();
      $display("NOT: aluout=%h NZP=%b", aluout, NZP);
      check("not_aluout", aluout, 16'hFF00);
      check("not_nzp", 16'(NZP), 16'h4);

      drive(16'hE1FE, 6'b000110, 2'b10, 16'h7777, 16'h2222, 16'h3001);
      tick();
      $display("LEA: pcout=%h NZP=%b W=%b", pcout, NZP, W_Control_out);
      check("lea_pcout", pcout, 16'h2FFF);
      check("lea_nzp", 16'(NZP), 16'h1);
      check("lea_wctl", 16'(W_Control_out), 16'h2);
      check("model_lea_pc", m_pc, 16'h2FFF);

      drive(16'h1261, 6'b000000, 2'b00, 16'hFFFF, 16'h0000, 16'h3000);
      tick();
      $display("ADD wrap: aluout=%h NZP=%b", aluout, NZP);
      check("wrap_aluout", aluout, 16'h0000);
      check("wrap_nzp", 16'(NZP), 16'h2);

      drive(16'h0020, 6'b001000, 2'b10, 16'h0100, 16'h0000, 16'h3000);
      tick();
      $display("off6 base VSR1: pcout=%h aluout=%h NZP=%b", pcout, aluout, NZP);
      check("off6_pcout", pcout, 16'h00E0);
      check("off6_aluout", aluout, 16'h0100);
      check("off6_nzp", 16'(NZP), 16'h1);

      drive(16'h1FFF, 6'b110000, 2'b01, 16'h8000, 16'h8000, 16'h3000);
      tick();
      $display("reserved alu/wctl: aluout=%h NZP=%b", aluout, NZP);
      check("rsvd_aluout", aluout, 16'h0000);
      check("rsvd_nzp", 16'(NZP), 16'h0);

      drive(16'hFFFF, 6'b111110, 2'b11, 16'h8000, 16'h8000, 16'h1234);
      tick();
      $display("zero offset: pcout=%h NZP=%b", pcout, NZP);
      check("zoff_pcout", pcout, 16'h1234);
      check("zoff_nzp", 16'(NZP), 16'h0);

      enable_execute = 1'b0;
      drive(16'h1042, 6'b000001, 2'b00, 16'h0001, 16'h0001, 16'h9999);
      tick();
      tick();
      $display("hold: pcout=%h W=%b", pcout, W_Control_out);
      check("hold_pcout", pcout, 16'h1234);
      check("hold_wctl", 16'(W_Control_out), 16'h3);

      enable_execute = 1'b1;
      drive(16'h1042, 6'b000001, 2'b00, 16'h0005, 16'h0003, 16'h3000);
      tick();
      $display("b2b 1: aluout=%h NZP=%b", aluout, NZP);
      check("b2b1_aluout", aluout, 16'h0008);
      check("b2b1_dr", 16'(dr), 16'h0);
      drive(16'h506F, 6'b010000, 2'b00, 16'h00FF, 16'h0000, 16'h3000);
      tick();
      $display("b2b 2: aluout=%h NZP=%b", aluout, NZP);
      check("b2b2_aluout", aluout, 16'h000F);
      check("b2b2_nzp", 16'(NZP), 16'h1);
      rst = 1'b1;
      drive(16'h927F, 6'b100000, 2'b00, 16'h00FF, 16'h0000, 16'h3000);
      tick();
      $display("b2b 3 (reset): aluout=%h IR_Exec=%h", aluout, IR_Exec);
      check("b2b3_aluout", aluout, 16'h0000);
      check("b2b3_ir", IR_Exec, 16'h0000);
      rst = 1'b0;
      drive(16'h1A7F, 6'b000000, 2'b00, 16'h0002, 16'h0000, 16'h3000);
      tick();
      $display("b2b 4: aluout=%h dr=%0d NZP=%b", aluout, dr, NZP);
      check("b2b4_aluout", aluout, 16'h0001);
      check("b2b4_dr", 16'(dr), 16'h5);
      check("b2b4_nzp", 16'(NZP), 16'h1);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
